// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the RSA modular exponentiation datapath.
package rsa_pkg;

  localparam int N       = 512;
  localparam int E_WIDTH = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TO_MONT,
    ST_SQUARE,
    ST_MULT,
    ST_FROM_MONT,
    ST_DONE
  } state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_TO_MONT   | xt = MM(base, R^2 mod M), acc preloaded with R mod M
// ST_SQUARE    | acc = MM(acc, acc), idx decrements on completion
// ST_MULT      | acc = MM(acc, xt) for a set exponent bit
// ST_FROM_MONT | acc = MM(acc, 1)
// ST_DONE      | result valid, done pulse
// Op states run an ISSUE phase (pulse mm_start) then a WAIT phase (hold for mm_done).
module mont_exp_ctrl #(
  parameter int N       = rsa_pkg::N,
  parameter int E_WIDTH = rsa_pkg::E_WIDTH,
  parameter int LW      = $clog2(E_WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N-1:0]       base,
  input  logic [E_WIDTH-1:0] exponent,
  input  logic [LW-1:0]      exp_len,
  input  logic [N-1:0]       modulus,
  input  logic [N-1:0]       r_mod_m,
  input  logic [N-1:0]       r2_mod_m,
  output logic [N-1:0]       result,
  output logic               done,
  output logic               busy,
  output logic               mm_start,
  output logic [N-1:0]       mm_a,
  output logic [N-1:0]       mm_b,
  output logic [N-1:0]       mm_m,
  input  logic [N-1:0]       mm_result,
  input  logic               mm_done
);
  import rsa_pkg::*;

  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [LW-1:0]        idx_q, idx_d;
  logic [E_WIDTH-1:0]   exp_q, exp_d;
  logic [N-1:0]         acc_q, acc_d;
  logic [N-1:0]         xt_q, xt_d;
  logic [N-1:0]         result_q, result_d;
  logic [N-1:0]         mm_a_q, mm_a_d;
  logic [N-1:0]         mm_b_q, mm_b_d;
  logic [N-1:0]         mm_m_q, mm_m_d;
  logic                 mm_start_q, mm_start_d;

  logic [LW-1:0]        idx_dec;
  logic                 bit_sel;

  // SQUARE is only entered with idx_q > 0, so idx_dec never wraps when used.
  assign idx_dec = idx_q - LW'(1);
  assign bit_sel = exp_q[idx_dec[IW-1:0]];

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    exp_d      = exp_q;
    acc_d      = acc_q;
    xt_d       = xt_q;
    result_d   = result_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_m_d     = mm_m_q;
    mm_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d   = exponent;
          idx_d   = exp_len;
          acc_d   = r_mod_m;
          mm_a_d  = base;
          mm_b_d  = r2_mod_m;
          mm_m_d  = modulus;
          state_d = ST_TO_MONT;
          phase_d = PH_ISSUE;
        end
      end

      ST_TO_MONT, ST_SQUARE, ST_MULT, ST_FROM_MONT: begin
        if (phase_q == PH_ISSUE) begin
          mm_start_d = 1'b1;
          phase_d    = PH_WAIT;
        end else if (mm_done) begin
          phase_d = PH_ISSUE;
          // Next operands are registered straight from mm_result so the
          // following mm_start can fire two cycles after mm_done.
          case (state_q)
            ST_TO_MONT: begin
              xt_d   = mm_result;
              mm_a_d = acc_q;
              if (idx_q != '0) begin
                state_d = ST_SQUARE;
                mm_b_d  = acc_q;
              end else begin
                state_d = ST_FROM_MONT;
                mm_b_d  = N'(ONE);
              end
            end
            ST_SQUARE: begin
              acc_d  = mm_result;
              idx_d  = idx_dec;
              mm_a_d = mm_result;
              if (bit_sel) begin
                state_d = ST_MULT;
                mm_b_d  = xt_q;
              end else if (idx_dec != '0) begin
                state_d = ST_SQUARE;
                mm_b_d  = mm_result;
              end else begin
                state_d = ST_FROM_MONT;
                mm_b_d  = N'(ONE);
              end
            end
            ST_MULT: begin
              acc_d  = mm_result;
              mm_a_d = mm_result;
              if (idx_q != '0) begin
                state_d = ST_SQUARE;
                mm_b_d  = mm_result;
              end else begin
                state_d = ST_FROM_MONT;
                mm_b_d  = N'(ONE);
              end
            end
            default: begin
              acc_d    = mm_result;
              result_d = mm_result;
              state_d  = ST_DONE;
            end
          endcase
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: begin
        state_d = ST_IDLE;
        phase_d = PH_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_ISSUE;
      idx_q      <= '0;
      exp_q      <= '0;
      acc_q      <= '0;
      xt_q       <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      exp_q      <= exp_d;
      acc_q      <= acc_d;
      xt_q       <= xt_d;
      result_q   <= result_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_m_q     <= mm_m_d;
      mm_start_q <= mm_start_d;
    end
  end

  assign result   = result_q;
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = mm_m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench: behavioural Montgomery multiplier with variable latency plus modexp reference.
module tb_mont_exp_ctrl;

  localparam int N     = 512;
  localparam int EW    = 512;
  localparam int LW    = $clog2(EW) + 1;
  localparam int LIMIT = 40000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  base, modulus, r_mod_m, r2_mod_m, result;
  logic [EW-1:0] exponent;
  logic [LW-1:0] exp_len;
  logic          done, busy, mm_start, mm_done;
  logic [N-1:0]  mm_a, mm_b, mm_m, mm_result;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.N(N), .E_WIDTH(EW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
    .exp_len(exp_len), .modulus(modulus), .r_mod_m(r_mod_m), .r2_mod_m(r2_mod_m),
    .result(result), .done(done), .busy(busy), .mm_start(mm_start),
    .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_result(mm_result), .mm_done(mm_done)
  );

  int checks = 0;
  int failures = 0;

  int           d_lat = 1;
  logic         stray = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] base_l = '0;
  logic [N-1:0] r2_l = '0;

  int           mstart_cnt;
  int           opnd_bad;
  byte          kinds[$];
  logic [N-1:0] lat_a, lat_b, lat_m, prev_a, prev_b, prev_m;
  logic         model_busy, done_real;
  int           rem;

  // a*b*2^-N mod m, bit-serial reduction
  function automatic logic [N-1:0] mont_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m);
    logic [N+1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] ref_modexp(input logic [N-1:0] b, input logic [EW-1:0] e,
                                              input int len, input logic [N-1:0] m);
    logic [2*N-1:0] r, bb, mm;
    mm = {{N{1'b0}}, m};
    bb = {{N{1'b0}}, b} % mm;
    r  = (2*N)'(1) % mm;
    for (int i = len - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] r_of(input logic [N-1:0] m);
    logic [2*N-1:0] t;
    t = ((2*N)'(1) << N) % {{N{1'b0}}, m};
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] r2_of(input logic [N-1:0] m);
    logic [2*N-1:0] r, t;
    r = {{N{1'b0}}, r_of(m)};
    t = (r * r) % {{N{1'b0}}, m};
    return t[N-1:0];
  endfunction

  function automatic byte classify(input int idx, input logic [N-1:0] a, input logic [N-1:0] b);
    if (idx == 0) return (a == base_l && b == r2_l) ? 8'h54 : 8'h3f;
    if (a == b) return 8'h53;
    if (b == N'(1)) return 8'h46;
    return 8'h4d;
  endfunction

  // Behavioural multiplier: mm_done D cycles after the mm_start cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_done    <= 1'b0;
      done_real  <= 1'b0;
      model_busy <= 1'b0;
      rem        <= 0;
      mm_result  <= '0;
      lat_a <= '0; lat_b <= '0; lat_m <= '0;
      prev_a <= '0; prev_b <= '0; prev_m <= '0;
      mstart_cnt <= 0;
      opnd_bad   <= 0;
    end else begin
      mm_done   <= 1'b0;
      done_real <= 1'b0;
      prev_a <= mm_a; prev_b <= mm_b; prev_m <= mm_m;
      if ((model_busy || done_real) && (mm_a != lat_a || mm_b != lat_b || mm_m != lat_m))
        opnd_bad <= opnd_bad + 1;
      if (clr) begin
        mstart_cnt <= 0;
        opnd_bad   <= 0;
        kinds.delete();
      end else if (mm_start) begin
        if (model_busy || mm_a != prev_a || mm_b != prev_b || mm_m != prev_m)
          opnd_bad <= opnd_bad + 1;
        kinds.push_back(classify(mstart_cnt, mm_a, mm_b));
        mstart_cnt <= mstart_cnt + 1;
        lat_a <= mm_a; lat_b <= mm_b; lat_m <= mm_m;
        mm_result <= mont_mul(mm_a, mm_b, mm_m);
        if (d_lat <= 1) begin
          mm_done   <= 1'b1;
          done_real <= 1'b1;
        end else begin
          rem        <= d_lat - 1;
          model_busy <= 1'b1;
        end
      end else if (model_busy) begin
        if (rem == 1) begin
          mm_done    <= 1'b1;
          done_real  <= 1'b1;
          model_busy <= 1'b0;
        end
        rem <= rem - 1;
      end else if (stray) begin
        mm_done   <= 1'b1;
        mm_result <= {16{$urandom()}};
      end
    end
  end

  task automatic chk_v(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic run_exp(input logic [N-1:0] b, input logic [EW-1:0] e, input int len,
                         input logic [N-1:0] m, input int d, input int glitch_at,
                         output logic [N-1:0] res, output int done_cyc, output int done_pulses);
    logic [N-1:0] r, r2;
    r  = r_of(m);
    r2 = r2_of(m);
    base_l = b;
    r2_l   = r2;
    d_lat  = d;
    res = '0;
    done_cyc = -1;
    done_pulses = 0;
    @(negedge clk);
    base = b; exponent = e; exp_len = LW'(len); modulus = m;
    r_mod_m = r; r2_mod_m = r2;
    start = 1'b1;
    clr   = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= LIMIT; j++) begin
      @(negedge clk);
      start = 1'b0;
      clr   = 1'b0;
      if (j == 1) chk_i("busy_cycle1", int'(busy), 1);
      if (j == glitch_at) begin
        start = 1'b1; base = ~b; exponent = '1; exp_len = LW'(5); modulus = N'(11);
      end
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = j;
          res = result;
        end
      end
      if (done_cyc >= 0 && j >= done_cyc + 3) break;
    end
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=none want=done within %0d cycles", LIMIT);
    end
  endtask

  task automatic check_run(input string tag, input logic [N-1:0] b, input logic [EW-1:0] e,
                           input int len, input logic [N-1:0] m, input int d,
                           input int glitch_at, input logic [N-1:0] want);
    logic [N-1:0]  res;
    logic [EW-1:0] em;
    int            dc, dp, kexp, diff;
    string         ks;
    em = '0;
    for (int i = 0; i < len; i++) em[i] = e[i];
    kexp = 2 + len + $countones(em);
    ks = "T";
    for (int i = len - 1; i >= 0; i--) begin
      ks = {ks, "S"};
      if (e[i]) ks = {ks, "M"};
    end
    ks = {ks, "F"};
    run_exp(b, e, len, m, d, glitch_at, res, dc, dp);
    chk_v({tag, " result"}, res, want);
    chk_i({tag, " mm_start_count"}, mstart_cnt, kexp);
    chk_i({tag, " done_cycle"}, dc, 2 + (kexp - 1) * (d + 2) + d + 1);
    chk_i({tag, " done_pulses"}, dp, 1);
    chk_i({tag, " operand_hold_errors"}, opnd_bad, 0);
    diff = -1;
    for (int i = 0; i < ks.len(); i++)
      if (diff < 0 && (i >= kinds.size() || kinds[i] != ks[i])) diff = i;
    if (diff < 0 && kinds.size() != ks.len()) diff = ks.len();
    chk_i({tag, " op_order_first_diff"}, diff, -1);
    chk_v({tag, " result_held"}, result, want);
    chk_i({tag, " busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [N-1:0]  b;
    logic [EW-1:0] e;
    int            len;
    logic [N-1:0]  m;
    int            d;
    int            glitch;
    logic [N-1:0]  want;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N-1:0]  rm, rb, rw;
    logic [EW-1:0] re;
    int            rlen, rd, w;

    vecs[0] = '{N'(5),  EW'(3),     2, N'(13),      4, 0, N'(8)};
    vecs[1] = '{N'(2),  EW'('hF0B), 4, N'(1000003), 3, 0, N'(2048)};
    vecs[2] = '{N'(9),  EW'('hFF),  0, N'(13),      2, 0, N'(1)};
    vecs[3] = '{N'(20), EW'(1),     1, N'(13),      5, 0, N'(7)};
    vecs[4] = '{N'(3),  EW'(5),     3, N'(1000003), 1, 0, N'(243)};
    vecs[5] = '{N'(5),  EW'(3),     2, N'(13),      4, 7, N'(8)};

    reset = 1'b1; start = 1'b0;
    base = '0; exponent = '0; exp_len = '0; modulus = '0; r_mod_m = '0; r2_mod_m = '0;
    repeat (3) @(negedge clk);
    chk_i("reset busy", int'(busy), 0);
    chk_i("reset done", int'(done), 0);
    chk_i("reset mm_start", int'(mm_start), 0);
    chk_v("reset result", result, '0);
    chk_v("reset mm_a", mm_a, '0);
    chk_v("reset mm_b", mm_b, '0);
    chk_v("reset mm_m", mm_m, '0);
    reset = 1'b0;

    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    chk_i("stray_mm_done busy", int'(busy), 0);
    chk_i("stray_mm_done mm_start", int'(mm_start), 0);

    for (int v = 0; v < 6; v++)
      check_run($sformatf("vec%0d", v), vecs[v].b, vecs[v].e, vecs[v].len, vecs[v].m,
                vecs[v].d, vecs[v].glitch, vecs[v].want);

    // reset in the middle of a WAIT phase
    d_lat = 4;
    base_l = N'(5);
    r2_l = r2_of(N'(13));
    @(negedge clk);
    base = N'(5); exponent = EW'(3); exp_len = LW'(2); modulus = N'(13);
    r_mod_m = r_of(N'(13)); r2_mod_m = r2_of(N'(13));
    start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    w = 0;
    while (!mm_start && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk_i("abort mm_start_seen", int'(mm_start), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_i("abort busy", int'(busy), 0);
    chk_i("abort mm_start", int'(mm_start), 0);
    chk_i("abort done", int'(done), 0);
    chk_v("abort result", result, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_run("after_abort", N'(5), EW'(3), 2, N'(13), 4, 0, N'(8));

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N / 32; i++) rm[i*32 +: 32] = $urandom();
      rm[N-1] = 1'b1;
      rm[0]   = 1'b1;
      for (int i = 0; i < N / 32; i++) rb[i*32 +: 32] = $urandom();
      rb = rb % rm;
      for (int i = 0; i < EW / 32; i++) re[i*32 +: 32] = $urandom();
      rlen = (r < 3) ? EW : int'($urandom_range(1, 64));
      rd = int'($urandom_range(1, 20));
      rw = ref_modexp(rb, re, rlen, rm);
      check_run($sformatf("rand%0d_d%0d", r, rd), rb, re, rlen, rm, rd, 0, rw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
